bit_stuff_error_block: RTL and testbench

- CAN receiver bit-stuff rule checker.
- Samples the received bus bit RX once per sample-point clock edge (SP).
- While stuff checking is enabled (F_STF=1), it counts consecutive equal bits. A sixth consecutive equal bit is a stuff error and raises STF_ERR.
- Sits beside the bit-timing/sampling logic and feeds the CAN error-handling block.

---
 rtl/bit_stuff_error_block_pkg.sv | 13 +
 rtl/bit_stuff_error_block_if.sv | 25 ++
 rtl/bit_stuff_error_block.sv | 50 +++++
 tb/tb_bit_stuff_error_block.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bit_stuff_error_block_pkg.sv
// Shared CAN constants for the receive-side rule checkers.
//   STUFF_LEN_DEF : consecutive equal bits allowed before a stuff bit is due
//   DOMINANT      : bus level 0
//   RECESSIVE     : bus level 1 (idle level)
package bit_stuff_error_block_pkg;

  localparam int unsigned STUFF_LEN_DEF = 5;
  localparam int unsigned CNT_W_DEF     = 3;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

endpackage

// File: rtl/bit_stuff_error_block_if.sv
// Bit-stream link between the bit-timing/sampling logic and the stuff checker.
//   RX      : sampled bus bit (0 dominant, 1 recessive)
//   F_STF   : stuff-check enable, high across stuffed frame fields
//   STF_ERR : registered stuff-error flag back to error handling
// master : sampling side (drives RX/F_STF, observes STF_ERR)
// slave  : checker side
interface bit_stuff_error_block_if;

  logic RX;
  logic F_STF;
  logic STF_ERR;

  modport master (
    output RX,
    output F_STF,
    input  STF_ERR
  );

  modport slave (
    input  RX,
    input  F_STF,
    output STF_ERR
  );

endinterface

// File: rtl/bit_stuff_error_block.sv
// CAN receiver bit-stuff rule checker.
// Counts consecutive equal bits while F_STF is high; a (STUFF_LEN+1)th equal
// bit sets a sticky STF_ERR that clears only on reset or a disabled edge.
// Ports:
//   SP    : sample-point clock, one RX bit per rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of bit_stuff_error_block_if (RX, F_STF in; STF_ERR out)
module bit_stuff_error_block
  import bit_stuff_error_block_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                    SP,
  input  logic                    reset,
  bit_stuff_error_block_if.slave  bus
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  logic             last_bit;
  logic [CNT_W-1:0] run_cnt;
  logic             err;

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      run_cnt  <= '0;
      last_bit <= RECESSIVE;
      err      <= 1'b0;
    end else if (!bus.F_STF) begin
      run_cnt  <= '0;
      last_bit <= bus.RX;
      err      <= 1'b0;
    end else if (run_cnt == '0 || bus.RX != last_bit) begin
      // first checked bit, or a level change (stuff bit starts the new run);
      // err is left untouched so the flag stays sticky
      last_bit <= bus.RX;
      run_cnt  <= RUN_ONE;
    end else if (run_cnt < RUN_MAX) begin
      run_cnt <= run_cnt + RUN_ONE;
    end else begin
      // saturated run with another equal bit
      err <= 1'b1;
    end
  end

  assign bus.STF_ERR = err;

endmodule

// File: tb/tb_bit_stuff_error_block.sv
// Scoreboarded bench for bit_stuff_error_block: the stimulus side pushes the
// expected STF_ERR for each sample edge; the monitor pops and compares after
// each edge. The reference keeps the checked bit history since the last
// enable/reset and looks at the length of its trailing equal-bit run.
module tb_bit_stuff_error_block;

  localparam int unsigned STUFF_LEN = 5;
  localparam int unsigned CNT_W     = 3;

  logic SP;
  logic reset;

  bit_stuff_error_block_if bus ();

  bit_stuff_error_block #(
    .STUFF_LEN (STUFF_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .SP    (SP),
    .reset (reset),
    .bus   (bus)
  );

  initial SP = 1'b0;
  always #5 SP = ~SP;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic exp_q[$];

  // reference model state
  logic hist[$];
  logic mdl_err = 1'b0;

  function automatic int unsigned trailing_run();
    int unsigned n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size()-1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_clear();
    hist.delete();
    mdl_err = 1'b0;
  endtask

  task automatic model_bit(input logic rx, input logic f);
    if (!f) begin
      model_clear();
    end else begin
      hist.push_back(rx);
      if (hist.size() > STUFF_LEN + 2) void'(hist.pop_front());
      if (trailing_run() > STUFF_LEN) mdl_err = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: STF_ERR=%b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // one sample edge with reset held active
  task automatic step_rst(input logic rx);
    @(negedge SP);
    reset = 1'b0;
    bus.RX = rx;
    bus.F_STF = 1'b1;
    model_clear();
    exp_q.push_back(mdl_err);
  endtask

  task automatic step(input logic rx, input logic f);
    @(negedge SP);
    reset = 1'b1;
    bus.RX = rx;
    bus.F_STF = f;
    model_bit(rx, f);
    exp_q.push_back(mdl_err);
  endtask

  // asynchronous reset pulse between edges, then a normal bit on the next edge
  task automatic step_pulse(input logic rx, input logic f);
    @(negedge SP);
    #1 reset = 1'b0;
    #1 check("async_reset", bus.STF_ERR, 1'b0);
    reset = 1'b1;
    model_clear();
    bus.RX = rx;
    bus.F_STF = f;
    model_bit(rx, f);
    exp_q.push_back(mdl_err);
  endtask

  // monitor
  initial begin
    logic e;
    forever begin
      @(posedge SP);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stf_err", bus.STF_ERR, e);
      end
    end
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev;
    logic rx;
    logic f;
    int unsigned r;
    reset = 1'b0;
    bus.RX = 1'b1;
    bus.F_STF = 1'b0;

    // reset held with RX toggling
    for (int i = 0; i < 6; i++) step_rst(logic'(i % 2));

    // disabled: long dominant run
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    // legal stuffing
    begin
      logic leg[11] = '{0,0,0,0,0,1,1,1,1,1,0};
      foreach (leg[i]) step(leg[i], 1'b1);
    end

    // stuff error and stickiness
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // clear via enable, then a legal 5-run
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

    // async reset mid-run
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step_pulse(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // async reset while the flag is set
    step_pulse(1'b0, 1'b1);

    // randomized traffic biased toward long runs
    prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      rx = ($urandom_range(0, 99) < 80) ? prev : ~prev;
      f  = (r >= 6);
      if (r == 0) step_pulse(rx, 1'b1);
      else        step(rx, f);
      prev = rx;
    end

    @(negedge SP);
    @(negedge SP);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
